// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared grid geometry, cell codes and arbiter enums
package grid_pkg;

    localparam int GRID_COLS  = 10;
    localparam int GRID_ROWS  = 24;
    localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;

    // Cell codes live in the low nibble of each grid RAM word.
    typedef enum logic [3:0] {
        CELL_AIR    = 4'd0,
        CELL_I      = 4'd1,
        CELL_O      = 4'd2,
        CELL_T      = 4'd3,
        CELL_S      = 4'd4,
        CELL_Z      = 4'd5,
        CELL_J      = 4'd6,
        CELL_L      = 4'd7,
        CELL_BORDER = 4'd8
    } cell_code_t;

    // Which requester the RAM read issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_GAME = 2'd2
    } owner_t;

    typedef enum logic {
        VID_PRI  = 1'b0,
        GAME_PRI = 1'b1
    } arb_state_t;

endpackage

// File: rtl/grid_arb_starve_ctr.sv
// rtl/grid_arb_starve_ctr.sv - saturating count of consecutive denied game cycles
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   inc         game requested and was denied this cycle; low clears the count
//   at_limit    count has saturated at LIMIT
module grid_arb_starve_ctr #(
    parameter int LIMIT = 8,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    output logic at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!inc) begin
            count <= '0;
        end else if (count != LIM) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIM);

endmodule

// File: rtl/grid_mem_arbiter.sv
// rtl/grid_mem_arbiter.sv - single-port grid RAM arbiter, video priority with game anti-starvation
// Optional build macro: GRID_ARB_BOUNDS_CHECK_EN (out-of-range addresses are consumed
// without touching RAM, reads return 0, err_oob pulses in the grant cycle).
// Ports:
//   clk, reset                           clock, synchronous active-high reset
//   vid_req/vid_addr                     video read request (never held off for long)
//   vid_stall                            video denied this cycle (combinational)
//   vid_valid/vid_data                   video read return, one cycle after grant
//   game_req/game_we/game_addr/game_wdata game access, held until game_gnt
//   game_gnt                             game accepted this cycle (combinational)
//   game_rvalid/game_rdata               game read return, one cycle after grant
//   err_oob                              out-of-range access pulse
//   mem_addr/mem_we/mem_wdata/mem_rdata  grid RAM port (1-cycle read latency)
module grid_mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int GRID_CELLS   = 240,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_stall,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [DATA_W-1:0] game_rdata,
    output logic              err_oob,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import grid_pkg::*;

`ifdef GRID_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    arb_state_t        state, state_nx;
    owner_t            owner_q, owner_nx;
    logic              rd_zero_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] vid_hold_q, game_hold_q;
    logic              vid_win, game_win, any_win, win_oob, starve_limit;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] rd_data;

    grid_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (game_req && !game_win),
        .at_limit (starve_limit)
    );

    // Grants are suppressed while reset is high so every output reads 0.
    always_comb begin
        state_nx = state;
        vid_win  = 1'b0;
        game_win = 1'b0;
        if (!reset) begin
            case (state)
                VID_PRI: begin
                    vid_win  = vid_req;
                    game_win = game_req && !vid_req;
                    // Counter saturated and still losing: force one game win next cycle.
                    if (starve_limit && game_req && !game_win) begin
                        state_nx = GAME_PRI;
                    end
                end
                GAME_PRI: begin
                    game_win = game_req;
                    vid_win  = vid_req && !game_req;
                    state_nx = VID_PRI;
                end
                default: state_nx = VID_PRI;
            endcase
        end
        any_win  = vid_win || game_win;
        win_addr = vid_win ? vid_addr : game_addr;
        win_oob  = BOUNDS_EN && any_win && (int'(win_addr) >= GRID_CELLS);
        if (vid_win) begin
            owner_nx = OWN_VID;
        end else if (game_win && !game_we) begin
            owner_nx = OWN_GAME;
        end else begin
            owner_nx = OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= VID_PRI;
            owner_q     <= OWN_NONE;
            rd_zero_q   <= 1'b0;
            addr_q      <= '0;
            vid_hold_q  <= '0;
            game_hold_q <= '0;
        end else begin
            state     <= state_nx;
            owner_q   <= owner_nx;
            rd_zero_q <= win_oob;
            if (any_win) begin
                addr_q <= win_addr;
            end
            if (vid_valid) begin
                vid_hold_q <= rd_data;
            end
            if (game_rvalid) begin
                game_hold_q <= rd_data;
            end
        end
    end

    // RAM port: the address holds while idle; out-of-range writes never reach the RAM.
    assign mem_addr  = any_win ? win_addr : (reset ? '0 : addr_q);
    assign mem_we    = game_win && game_we && !win_oob;
    assign mem_wdata = (game_win && game_we) ? game_wdata : '0;
    assign err_oob   = win_oob;

    assign vid_stall = vid_req && !vid_win && !reset;
    assign game_gnt  = game_win;

    assign rd_data     = rd_zero_q ? '0 : mem_rdata;
    assign vid_valid   = !reset && (owner_q == OWN_VID);
    assign game_rvalid = !reset && (owner_q == OWN_GAME);
    assign vid_data    = reset ? '0 : (vid_valid ? rd_data : vid_hold_q);
    assign game_rdata  = reset ? '0 : (game_rvalid ? rd_data : game_hold_q);

endmodule
